dac_write_sequencer: RTL and testbench
======================================

DAC_WRITE_SEQUENCER -- requirements
Module: dac_write_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h60, 7-bit I2C address of the MCP47FEB DAC.
REQ-002 SHALL have parameter STARTUP_CYCLES, default 100000, idle cycles after reset before the first transaction.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum cycles spent in any one transaction.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_channel in 1, req_value in 12: user write request (channel 0/1, 12-bit code).
REQ-007 SHALL have status ports busy out 1, done out 1, error out 1, timeout out 1.
REQ-008 SHALL have i2c_master command ports cmd_address out 7, cmd_start out 1, cmd_read out 1, cmd_write out 1, cmd_write_multiple out 1, cmd_stop out 1, cmd_valid out 1, cmd_ready in 1.
REQ-009 SHALL have i2c_master data ports data_in out 8, data_in_valid out 1, data_in_ready in 1, data_in_last out 1, data_out_ready out 1, i2c_busy in 1, missed_ack in 1.

Function
REQ-010 SHALL hold one value register and one pending flag per channel.
REQ-011 SHALL drive req_ready high in every state except STARTUP.
REQ-012 On req_valid&&req_ready, SHALL overwrite val[req_channel] and set pend[req_channel]; later requests replace earlier undispatched ones.
REQ-013 SHALL use states STARTUP, IDLE, CMD, B0, B1, B2, WAIT, DONE.
REQ-014 STARTUP: counter runs; SHALL enter IDLE when the count reaches STARTUP_CYCLES.
REQ-015 IDLE: if any pend bit is set, SHALL select a channel, snapshot its value into tx_value, clear its pend bit in the same cycle, and enter CMD.
REQ-016 Selection when both are pending SHALL be round-robin: pick the channel not served last; after reset, channel 0 is first.
REQ-017 If a request for the selected channel arrives in the dispatch cycle, SHALL leave pend set, so the new value is written by a later transaction.
REQ-018 CMD: SHALL assert cmd_valid with cmd_start=cmd_write_multiple=cmd_stop=1, cmd_read=cmd_write=0 and cmd_address=DEV_ADDR; it SHALL enter B0 on the cycle cmd_valid&&cmd_ready.
REQ-019 B0/B1/B2: SHALL present data_in with data_in_valid=1 and advance on data_in_valid&&data_in_ready.
REQ-020 Byte B0 = {4'b0000, ch, 3'b000} (0x00 or 0x08); byte B1 = {4'h0, tx_value[11:8]}; byte B2 = tx_value[7:0].
REQ-021 data_in_last SHALL be 1 only in B2.
REQ-022 WAIT: SHALL enter DONE when i2c_busy is low.
REQ-023 The missed_ack input SHALL be OR-ed into an internal sticky flag; the flag is cleared on dispatch.
REQ-024 A timeout counter SHALL clear on dispatch and count in CMD through WAIT; on reaching TIMEOUT_CYCLES it SHALL set timeout and force DONE.
REQ-025 DONE: SHALL pulse done for exactly one cycle, with error = sticky flag OR timeout for that cycle; it then returns to IDLE.
REQ-026 Failed writes SHALL NOT be retried.
REQ-027 timeout SHALL stay set until reset.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 data_out_ready SHALL be constant 0.
REQ-030 Outputs SHALL be registered.
REQ-031 Minimum latency from dispatch to done SHALL be 5 cycles plus bus time.

Reset
REQ-032 While rst=1, all outputs SHALL be 0 except cmd_address, which SHALL be DEV_ADDR.
REQ-033 While rst=1, state SHALL be STARTUP, pend=0, val=0, counters=0, and last-served SHALL be channel 1.
REQ-034 Reset mid-transaction SHALL abandon it immediately; the i2c_master is reset by the same rst.

Structure
REQ-035 A shared package SHALL hold the state encoding, the MCP47FEB register addresses (DAC0=5'h00, DAC1=5'h01) and the write command code 2'b00.
REQ-036 SHALL be a single module with no sub-modules.
REQ-037 The round-robin picker SHALL be inline logic.

Verification
REQ-038 Startup: req_ready=0 until STARTUP_CYCLES elapses (set to 16 in the bench), then 1; a request during startup is not accepted.
REQ-039 Single write: ch1, value 0xABC -> cmd_address 0x60 with all flags set; then bytes 0x08, 0x0A, 0xBC, last only on 0xBC; then one done pulse with error=0.
REQ-040 Coalescing: ch0 values 0x111 then 0x222 both sent while busy -> exactly one further transaction, carrying 0x02/0x22.
REQ-041 Arbitration: ch0 and ch1 pending together after reset -> ch0 transaction first, then ch1.
REQ-042 Missed ACK: missed_ack pulsed during B1 -> done with error=1 and no retry; the next transaction reports error=0.
REQ-043 Timeout and reset: cmd_ready held 0 -> done, error and timeout after TIMEOUT_CYCLES (set to 64 in the bench); rst asserted in B1 -> all outputs zero (cmd_address=0x60) and state STARTUP.

Source files
------------

// File: rtl/dac_write_sequencer_pkg.sv
// Shared definitions for the MCP47FEB DAC write sequencer:
// FSM encoding, device register map and command-byte helper.
package dac_write_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_STARTUP = 3'd0,
      ST_IDLE    = 3'd1,
      ST_CMD     = 3'd2,
      ST_B0      = 3'd3,
      ST_B1      = 3'd4,
      ST_B2      = 3'd5,
      ST_WAIT    = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   localparam logic [4:0] REG_DAC0  = 5'h00;
   localparam logic [4:0] REG_DAC1  = 5'h01;
   localparam logic [1:0] CMD_WRITE = 2'b00;

   // First byte of a register write: {register, command, 1'b0}
   function automatic logic [7:0] cmd_byte(input logic ch);
      return {(ch ? REG_DAC1 : REG_DAC0), CMD_WRITE, 1'b0};
   endfunction

endpackage

// File: rtl/dac_write_sequencer_if.sv
// Command/data link between the DAC write sequencer and an i2c_master.
interface dac_write_sequencer_if;
   logic [6:0] cmd_address;
   logic       cmd_start;
   logic       cmd_read;
   logic       cmd_write;
   logic       cmd_write_multiple;
   logic       cmd_stop;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;
   logic       data_in_last;
   logic       data_out_ready;
   logic       i2c_busy;
   logic       missed_ack;

   modport master (
      output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
             cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last, data_out_ready,
      input  cmd_ready, data_in_ready, i2c_busy, missed_ack
   );

   modport slave (
      input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
             cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last, data_out_ready,
      output cmd_ready, data_in_ready, i2c_busy, missed_ack
   );
endinterface

// File: rtl/dac_write_sequencer.sv
// Two-channel MCP47FEB write sequencer: coalesces user requests per channel and
// issues one 3-byte I2C register write per dispatch, round-robin between channels.
module dac_write_sequencer
   import dac_write_sequencer_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR       = 7'h60,
   parameter int         STARTUP_CYCLES = 100000,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_channel,
   input  logic [11:0]           req_value,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  timeout,
   dac_write_sequencer_if.master i2c
);

   localparam int SW = $clog2(STARTUP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] S_END = SW'(STARTUP_CYCLES);
   localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYCLES);

   state_t           state, state_n;
   logic [SW-1:0]    scnt, scnt_n;
   logic [TW-1:0]    tcnt, tcnt_n;
   logic [1:0]       pend, pend_n;
   logic [1:0][11:0] val;
   logic             last_ch, sel, accept, dispatch, active;
   logic [11:0]      tx_value;
   logic             tx_ch;
   logic             sticky, sticky_n, tmo, tmo_n;
   logic [7:0]       byte_n;

   logic             req_ready_q, busy_q, done_q, error_q;
   logic             cmd_valid_q, dv_q, last_q;
   logic [7:0]       data_q;

   assign accept = req_valid && req_ready_q;
   assign active = state inside {ST_CMD, ST_B0, ST_B1, ST_B2, ST_WAIT};
   // Both pending: serve the channel not served last; otherwise whichever is set.
   assign sel    = (pend == 2'b11) ? ~last_ch : pend[1];

   always_comb begin
      state_n  = state;
      scnt_n   = scnt;
      tcnt_n   = tcnt;
      dispatch = 1'b0;
      tmo_n    = tmo;
      case (state)
         ST_STARTUP: begin
            scnt_n = scnt + 1'b1;
            if (scnt_n == S_END) state_n = ST_IDLE;
         end
         ST_IDLE: begin
            if (|pend) begin
               dispatch = 1'b1;
               tcnt_n   = '0;
               state_n  = ST_CMD;
            end
         end
         ST_CMD:  if (cmd_valid_q && i2c.cmd_ready) state_n = ST_B0;
         ST_B0:   if (dv_q && i2c.data_in_ready) state_n = ST_B1;
         ST_B1:   if (dv_q && i2c.data_in_ready) state_n = ST_B2;
         ST_B2:   if (dv_q && i2c.data_in_ready) state_n = ST_WAIT;
         ST_WAIT: if (!i2c.i2c_busy) state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_STARTUP;
      endcase
      // Watchdog overrides any normal progress through the transaction.
      if (active) begin
         tcnt_n = tcnt + 1'b1;
         if (tcnt_n == T_END) begin
            tmo_n   = 1'b1;
            state_n = ST_DONE;
         end
      end
   end

   always_comb begin
      sticky_n = dispatch ? 1'b0 : (sticky | i2c.missed_ack);
      pend_n   = pend;
      if (dispatch) pend_n[sel] = 1'b0;
      // A same-cycle request to the dispatched channel keeps it pending.
      if (accept) pend_n[req_channel] = 1'b1;
   end

   always_comb begin
      byte_n = 8'h00;
      case (state_n)
         ST_B0:   byte_n = cmd_byte(tx_ch);
         ST_B1:   byte_n = {4'h0, tx_value[11:8]};
         ST_B2:   byte_n = tx_value[7:0];
         default: byte_n = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_STARTUP;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt        <= '0;
         tcnt        <= '0;
         pend        <= '0;
         val         <= '0;
         last_ch     <= 1'b1;
         tx_value    <= '0;
         tx_ch       <= 1'b0;
         sticky      <= 1'b0;
         tmo         <= 1'b0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         dv_q        <= 1'b0;
         last_q      <= 1'b0;
         data_q      <= '0;
      end else begin
         scnt   <= scnt_n;
         tcnt   <= tcnt_n;
         pend   <= pend_n;
         sticky <= sticky_n;
         tmo    <= tmo_n;
         if (accept) val[req_channel] <= req_value;
         if (dispatch) begin
            tx_value <= val[sel];
            tx_ch    <= sel;
            last_ch  <= sel;
         end
         req_ready_q <= (state_n != ST_STARTUP);
         busy_q      <= (state_n != ST_IDLE);
         done_q      <= (state_n == ST_DONE);
         error_q     <= (state_n == ST_DONE) && (sticky_n || tmo_n);
         cmd_valid_q <= (state_n == ST_CMD);
         dv_q        <= (state_n inside {ST_B0, ST_B1, ST_B2});
         last_q      <= (state_n == ST_B2);
         data_q      <= byte_n;
      end
   end

   assign req_ready              = req_ready_q;
   assign busy                   = busy_q;
   assign done                   = done_q;
   assign error                  = error_q;
   assign timeout                = tmo;
   assign i2c.cmd_address        = DEV_ADDR;
   assign i2c.cmd_start          = cmd_valid_q;
   assign i2c.cmd_read           = 1'b0;
   assign i2c.cmd_write          = 1'b0;
   assign i2c.cmd_write_multiple = cmd_valid_q;
   assign i2c.cmd_stop           = cmd_valid_q;
   assign i2c.cmd_valid          = cmd_valid_q;
   assign i2c.data_in            = data_q;
   assign i2c.data_in_valid      = dv_q;
   assign i2c.data_in_last       = last_q;
   assign i2c.data_out_ready     = 1'b0;

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Bench for dac_write_sequencer: behavioural i2c_master, table vectors,
// corner-case sequences and a randomized run against a per-channel scoreboard.
module tb_dac_write_sequencer;
   import dac_write_sequencer_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_channel = 1'b0;
   logic [11:0] req_value = '0;
   logic        req_ready, busy, done, error, timeout;

   dac_write_sequencer_if i2c();

   dac_write_sequencer #(.DEV_ADDR(7'h60), .STARTUP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_channel(req_channel), .req_value(req_value), .busy(busy), .done(done),
      .error(error), .timeout(timeout), .i2c(i2c)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]  addr;
      logic [4:0]  flags;   // {start, read, write, write_multiple, stop}
      logic [23:0] bytes;   // {b0, b1, b2}
      logic [2:0]  last;    // data_in_last per byte
   } txn_t;

   typedef struct {
      logic        ch;
      logic [11:0] val;
      logic [23:0] exp;
      logic        stall;
   } vec_t;

   int   checks = 0, errors = 0;
   bit   cmd_ready_en = 1'b1, stall_en = 1'b0, ack_fault = 1'b0;
   bit   bus_active;
   int   tail, cur_idx, done_cnt = 0, err_cnt = 0;
   logic last_err, last_tmo;
   txn_t cur;
   txn_t txn_q[$];

   // Behavioural i2c_master: inputs change at negedge, handshakes land on the next posedge.
   always @(negedge clk) begin
      if (rst) begin
         i2c.cmd_ready = 1'b0; i2c.data_in_ready = 1'b0;
         i2c.i2c_busy = 1'b0;  i2c.missed_ack = 1'b0;
         bus_active = 1'b0; tail = 0; cur_idx = 0;
      end else begin
         i2c.cmd_ready     = cmd_ready_en;
         i2c.data_in_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         i2c.missed_ack    = ack_fault && i2c.data_in_valid && (cur_idx == 1);
         if (i2c.cmd_valid && i2c.cmd_ready) begin
            cur.addr  = i2c.cmd_address;
            cur.flags = {i2c.cmd_start, i2c.cmd_read, i2c.cmd_write,
                         i2c.cmd_write_multiple, i2c.cmd_stop};
            cur.bytes = '0; cur.last = '0; cur_idx = 0; bus_active = 1'b1;
         end
         if (i2c.data_in_valid && i2c.data_in_ready) begin
            cur.bytes = {cur.bytes[15:0], i2c.data_in};
            cur.last  = {cur.last[1:0], i2c.data_in_last};
            cur_idx++;
            if (cur_idx == 3) begin txn_q.push_back(cur); tail = 3; end
         end else if (tail > 0) begin
            tail--;
            if (tail == 0) bus_active = 1'b0;
         end
         i2c.i2c_busy = bus_active;
         if (done) begin
            done_cnt++; last_err = error; last_tmo = timeout;
            if (error) err_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic send(input logic ch, input logic [11:0] v);
      req_valid = 1'b1; req_channel = ch; req_value = v;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_dones(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 400) begin tick(); n++; end
      check(name, 32'(done_cnt >= target), 1);
   endtask

   task automatic check_txn(input string name, input int idx, input logic [23:0] exp);
      check({name, "_present"}, 32'(txn_q.size() > idx), 1);
      if (txn_q.size() > idx) begin
         check({name, "_addr"},  32'(txn_q[idx].addr), 32'h60);
         check({name, "_flags"}, 32'(txn_q[idx].flags), 32'b10011);
         check({name, "_bytes"}, 32'(txn_q[idx].bytes), 32'(exp));
         check({name, "_last"},  32'(txn_q[idx].last), 32'b001);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({req_ready, busy, done, error, timeout, i2c.cmd_start, i2c.cmd_read,
                  i2c.cmd_write, i2c.cmd_write_multiple, i2c.cmd_stop, i2c.cmd_valid,
                  i2c.data_in, i2c.data_in_valid, i2c.data_in_last, i2c.data_out_ready});
   endfunction

   initial begin
      vec_t        vecs[5];
      int          base, dbase, ebase, n;
      logic [11:0] exp0[$], exp1[$];

      vecs[0] = '{ch: 1'b1, val: 12'hABC, exp: 24'h080ABC, stall: 1'b0};
      vecs[1] = '{ch: 1'b0, val: 12'h000, exp: 24'h000000, stall: 1'b0};
      vecs[2] = '{ch: 1'b1, val: 12'hFFF, exp: 24'h080FFF, stall: 1'b1};
      vecs[3] = '{ch: 1'b0, val: 12'h5A3, exp: 24'h0005A3, stall: 1'b1};
      vecs[4] = '{ch: 1'b0, val: 12'h800, exp: 24'h000800, stall: 1'b0};

      // Reset values
      repeat (3) tick();
      check("rst_outs", outs(), 0);
      check("rst_addr", 32'(i2c.cmd_address), 32'h60);

      // Startup window: a request held during startup must not be taken
      req_valid = 1'b1; req_channel = 1'b0; req_value = 12'h123;
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1 check("startup_ready_lo", 32'(req_ready), 0);
      @(posedge clk);
      #1 check("startup_ready_hi", 32'(req_ready), 1);
      req_valid = 1'b0;
      repeat (20) tick();
      check("startup_no_txn", 32'(txn_q.size()), 0);
      check("startup_no_done", 32'(done_cnt), 0);
      check("startup_idle", 32'(busy), 0);

      // Table vectors
      foreach (vecs[i]) begin
         base = txn_q.size(); dbase = done_cnt;
         stall_en = vecs[i].stall;
         send(vecs[i].ch, vecs[i].val);
         wait_dones(dbase + 1, "vec_done");
         check_txn("vec", base, vecs[i].exp);
         check("vec_err", 32'(last_err), 0);
         check("vec_tmo", 32'(last_tmo), 0);
         repeat (5) tick();
      end
      stall_en = 1'b0;

      // Coalescing: two ch0 updates during a busy write collapse to the later one
      base = txn_q.size(); dbase = done_cnt;
      send(1'b1, 12'h777);
      repeat (3) tick();
      send(1'b0, 12'h111);
      send(1'b0, 12'h222);
      wait_dones(dbase + 2, "coal_done");
      repeat (30) tick();
      check("coal_count", 32'(txn_q.size() - base), 2);
      check_txn("coal_a", base, 24'h080777);
      check_txn("coal_b", base + 1, 24'h000222);

      // Round-robin with both channels pending, in both request orders
      base = txn_q.size(); dbase = done_cnt;
      send(1'b0, 12'h0AA);
      repeat (2) tick();
      send(1'b0, 12'h0BB);
      send(1'b1, 12'h1CC);
      wait_dones(dbase + 3, "rr1_done");
      check_txn("rr1_a", base, 24'h0000AA);
      check_txn("rr1_b", base + 1, 24'h0801CC);
      check_txn("rr1_c", base + 2, 24'h0000BB);
      repeat (5) tick();
      base = txn_q.size(); dbase = done_cnt;
      send(1'b1, 12'h2DD);
      repeat (2) tick();
      send(1'b1, 12'h2EE);
      send(1'b0, 12'h3FF);
      wait_dones(dbase + 3, "rr2_done");
      check_txn("rr2_a", base, 24'h0802DD);
      check_txn("rr2_b", base + 1, 24'h0003FF);
      check_txn("rr2_c", base + 2, 24'h0802EE);
      repeat (10) tick();

      // Missed ACK during B1: error reported once, no retry, next write clean
      base = txn_q.size(); dbase = done_cnt;
      ack_fault = 1'b1;
      send(1'b0, 12'h456);
      wait_dones(dbase + 1, "nack_done");
      ack_fault = 1'b0;
      check("nack_err", 32'(last_err), 1);
      check_txn("nack", base, 24'h000456);
      repeat (30) tick();
      check("nack_no_retry", 32'(txn_q.size() - base), 1);
      check("nack_one_done", 32'(done_cnt - dbase), 1);
      send(1'b1, 12'h789);
      wait_dones(dbase + 2, "nack_next_done");
      check("nack_next_err", 32'(last_err), 0);
      repeat (5) tick();

      // Randomized traffic against per-channel ordered scoreboard
      base = txn_q.size(); dbase = done_cnt; ebase = err_cnt;
      stall_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic        ch;
         logic [11:0] v;
         ch = 1'($urandom_range(0, 1));
         v  = 12'($urandom_range(0, 4095));
         if (ch) exp1.push_back(v); else exp0.push_back(v);
         send(ch, v);
         repeat ($urandom_range(0, 10)) tick();
      end
      repeat (300) tick();
      stall_en = 1'b0;
      for (int i = base; i < txn_q.size(); i++) begin
         logic        ch, found;
         logic [11:0] v;
         ch = (txn_q[i].bytes[23:16] == 8'h08);
         v  = {txn_q[i].bytes[11:8], txn_q[i].bytes[7:0]};
         check("rand_hdr", 32'({txn_q[i].bytes[23:16] & 8'hF7, txn_q[i].bytes[15:12]}), 0);
         found = 1'b0;
         if (ch) begin
            while (exp1.size() > 0 && !found) found = (exp1.pop_front() == v);
         end else begin
            while (exp0.size() > 0 && !found) found = (exp0.pop_front() == v);
         end
         check("rand_order", 32'(found), 1);
      end
      check("rand_final_ch0", 32'(exp0.size()), 0);
      check("rand_final_ch1", 32'(exp1.size()), 0);
      check("rand_dones", 32'(done_cnt - dbase), 32'(txn_q.size() - base));
      check("rand_errs", 32'(err_cnt - ebase), 0);

      // Timeout: command never accepted
      base = txn_q.size(); dbase = done_cnt;
      cmd_ready_en = 1'b0;
      send(1'b0, 12'h100);
      n = 0;
      while (done_cnt == dbase && n < 200) begin tick(); n++; end
      check("tmo_done", 32'(done_cnt - dbase), 1);
      check("tmo_latency", 32'(n >= 64 && n <= 67), 1);
      check("tmo_err", 32'(last_err), 1);
      check("tmo_flag", 32'(last_tmo), 1);
      check("tmo_no_bytes", 32'(txn_q.size() - base), 0);
      repeat (5) tick();
      check("tmo_sticky", 32'(timeout), 1);
      cmd_ready_en = 1'b1;

      // Reset in the middle of B1
      send(1'b1, 12'hABC);
      n = 0;
      while (!(i2c.data_in_valid && i2c.data_in == 8'h0A) && n < 50) begin tick(); n++; end
      check("rstmid_reach_b1", 32'(n < 50), 1);
      rst = 1'b1;
      #1;
      check("rstmid_outs", outs(), 0);
      check("rstmid_addr", 32'(i2c.cmd_address), 32'h60);
      check("rstmid_state", 32'(dut.state), 32'(ST_STARTUP));
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("rstmid_ready_lo", 32'(req_ready), 0);
      check("rstmid_busy", 32'(busy), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
